// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one unified memory bus between instruction fetch
// (read-only) and the MEM stage (load/store). Each access is a registered
// bus command held until bus_rdy. MEM has priority, but IF is guaranteed a
// grant after at most STARVE_LIMIT consecutive MEM grants while it waits.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_dout,
  output logic        if_done,
  output logic        if_stall,

  input  logic [1:0]  mem_cmd,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_done,
  output logic        mem_stall,

  output logic [1:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_din,
  input  logic [31:0] bus_dout,
  input  logic        bus_rdy
);

  // Bus command encodings shared with the rest of the pipeline.
  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;
  localparam logic [1:0] BUS_NA    = 2'b11;

  // The streak counter must be able to hold STARVE_LIMIT itself.
  localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_BUSY_IF  = 2'b01,
    S_BUSY_MEM = 2'b10
  } state_t;

  state_t              state_q;
  logic [STREAK_W-1:0] streak_q;
  logic [1:0]          bus_cmd_q;
  logic [31:0]         bus_addr_q;
  logic [31:0]         bus_din_q;

  logic mem_req_s;
  logic if_forced_s;
  logic mem_grant_s;
  logic if_grant_s;

  // Arbitration decision for the current IDLE cycle; BUS_NA counts as no request.
  always_comb begin
    mem_req_s   = (mem_cmd == BUS_LOAD) || (mem_cmd == BUS_STORE);
    if_forced_s = if_req && (streak_q == STREAK_MAX);
    if (state_q == S_IDLE) begin
      mem_grant_s = mem_req_s && !if_forced_s;
      if_grant_s  = if_req && !mem_grant_s;
    end else begin
      mem_grant_s = 1'b0;
      if_grant_s  = 1'b0;
    end
  end

  // Bus FSM: grants from IDLE, holds the registered command until bus_rdy,
  // and tracks how many MEM grants in a row have made IF wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      streak_q   <= STREAK_ZERO;
      bus_cmd_q  <= BUS_NONE;
      bus_addr_q <= 32'h0000_0000;
      bus_din_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_grant_s) begin
            state_q    <= S_BUSY_MEM;
            bus_cmd_q  <= mem_cmd;
            bus_addr_q <= mem_addr;
            bus_din_q  <= mem_din;
            if (!if_req) begin
              streak_q <= STREAK_ZERO;
            end else if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + STREAK_ONE;
            end else begin
              streak_q <= streak_q;
            end
          end else if (if_grant_s) begin
            state_q    <= S_BUSY_IF;
            bus_cmd_q  <= BUS_LOAD;
            bus_addr_q <= if_addr;
            bus_din_q  <= 32'h0000_0000;
            streak_q   <= STREAK_ZERO;
          end else begin
            // Nothing to grant; bus_rdy seen here is spurious and ignored.
            state_q   <= S_IDLE;
            bus_cmd_q <= BUS_NONE;
            streak_q  <= STREAK_ZERO;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          // Address and data stay put through wait states and after completion.
          if (bus_rdy) begin
            state_q   <= S_IDLE;
            bus_cmd_q <= BUS_NONE;
          end else begin
            state_q   <= state_q;
            bus_cmd_q <= bus_cmd_q;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bus_cmd_q <= BUS_NONE;
        end
      endcase
    end
  end

  // Completion strobes, stalls and read-data routing are combinational.
  always_comb begin
    if_done   = (state_q == S_BUSY_IF)  && bus_rdy;
    mem_done  = (state_q == S_BUSY_MEM) && bus_rdy;
    if_stall  = if_req && !if_done;
    mem_stall = mem_req_s && !mem_done;
    if_dout   = bus_dout;
    mem_dout  = bus_dout;
  end

  assign bus_cmd  = bus_cmd_q;
  assign bus_addr = bus_addr_q;
  assign bus_din  = bus_din_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter. A transaction-level
// reference (which requester owns the bus, what was latched at grant, and
// how many MEM wins IF has sat through) predicts every output each cycle.
module tb_mem_bus_arbiter;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;
  localparam logic [1:0] NA    = 2'b11;
  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_dout;
  logic        if_done, if_stall;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_done, mem_stall;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr, bus_din, bus_dout;
  logic        bus_rdy;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_dout(if_dout),
    .if_done(if_done), .if_stall(if_stall),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_done(mem_done), .mem_stall(mem_stall),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_rdy(bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: current bus owner and what it latched at grant.
  bit          m_busy;
  bit          m_own_mem;
  logic [1:0]  m_cmd;
  logic [31:0] m_addr, m_din;
  int          m_wins;
  bit          last_ifd, last_memd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_own_mem = 1'b0; m_cmd = NONE;
    m_addr = 32'h0; m_din = 32'h0; m_wins = 0;
    last_ifd = 1'b0; last_memd = 1'b0;
  endtask

  // One clock cycle: inputs are already driven (we sit just after a negedge).
  task automatic step();
    bit e_ifd, e_memd, mreq;
    #1;
    mreq   = (mem_cmd == LOAD) || (mem_cmd == STORE);
    e_ifd  = m_busy && !m_own_mem && bus_rdy;
    e_memd = m_busy &&  m_own_mem && bus_rdy;
    chk("if_done",   32'(if_done),   32'(e_ifd));
    chk("mem_done",  32'(mem_done),  32'(e_memd));
    chk("if_stall",  32'(if_stall),  32'(if_req && !e_ifd));
    chk("mem_stall", 32'(mem_stall), 32'(mreq && !e_memd));
    if (e_ifd) chk("if_dout", if_dout, bus_dout);
    if (e_memd && m_cmd == LOAD) chk("mem_dout", mem_dout, bus_dout);
    last_ifd  = e_ifd;
    last_memd = e_memd;
    if (!m_busy) begin
      if (mreq && !(if_req && m_wins == LIMIT)) begin
        m_busy = 1'b1; m_own_mem = 1'b1;
        m_cmd = mem_cmd; m_addr = mem_addr; m_din = mem_din;
        m_wins = if_req ? ((m_wins < LIMIT) ? m_wins + 1 : LIMIT) : 0;
      end else if (if_req) begin
        m_busy = 1'b1; m_own_mem = 1'b0;
        m_cmd = LOAD; m_addr = if_addr; m_din = 32'h0;
        m_wins = 0;
      end else begin
        m_wins = 0;
      end
    end else if (bus_rdy) begin
      m_busy = 1'b0;
      m_cmd  = NONE;
    end
    @(posedge clk);
    #1;
    chk("bus_cmd",  32'(bus_cmd), 32'(m_cmd));
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_din",  bus_din,  m_din);
    @(negedge clk);
  endtask

  int  mem_grants;
  bit  got_if;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    mem_cmd = NONE; mem_addr = 32'h0; mem_din = 32'h0;
    bus_dout = 32'h0; bus_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_cmd",  32'(bus_cmd), 32'(NONE));
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_din",  bus_din,  32'h0);
    chk("rst_ifd",  32'(if_done),  32'h0);
    chk("rst_memd", 32'(mem_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: single IF read, memory ready on the first bus cycle.
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("t1_cmd",  32'(bus_cmd), 32'(LOAD));
    chk("t1_addr", bus_addr, 32'h100);
    bus_rdy = 1'b1; bus_dout = 32'hDEADBEEF;
    #1;
    chk("t1_done", 32'(if_done), 32'h1);
    chk("t1_dout", if_dout, 32'hDEADBEEF);
    step();
    chk("t1_idle", 32'(bus_cmd), 32'(NONE));
    if_req = 1'b0; bus_rdy = 1'b0;
    step();

    // 2: IF and MEM store together, store sees two wait states.
    if_req = 1'b1; if_addr = 32'h200;
    mem_cmd = STORE; mem_addr = 32'h40; mem_din = 32'h12345678;
    step();
    chk("t2_cmd",  32'(bus_cmd), 32'(STORE));
    chk("t2_addr", bus_addr, 32'h40);
    chk("t2_din",  bus_din,  32'h12345678);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t2_ifstall", 32'(if_stall), 32'h1);
      step();
      chk("t2_hold", 32'(bus_cmd), 32'(STORE));
    end
    bus_rdy = 1'b1;
    #1;
    chk("t2_memdone", 32'(mem_done), 32'h1);
    chk("t2_ifstall_end", 32'(if_stall), 32'h1);
    step();
    mem_cmd = NONE; bus_rdy = 1'b0;
    step();
    chk("t2_if_cmd",  32'(bus_cmd), 32'(LOAD));
    chk("t2_if_addr", bus_addr, 32'h200);
    bus_rdy = 1'b1; step();
    if_req = 1'b0; bus_rdy = 1'b0; step();

    // 3: back-to-back MEM loads while IF waits.
    if_req = 1'b1; if_addr = 32'h300;
    mem_cmd = LOAD; mem_addr = 32'h1000;
    mem_grants = 0; got_if = 1'b0;
    for (int i = 0; i < 10 && !got_if; i++) begin
      bus_rdy = 1'b0; step();
      if (bus_addr === 32'h300) got_if = 1'b1;
      else mem_grants++;
      bus_rdy = 1'b1; bus_dout = $urandom; step();
      mem_addr = mem_addr + 32'h4;
    end
    chk("t3_mem_grants", 32'(mem_grants), 32'd4);
    chk("t3_if_won", 32'(got_if), 32'h1);
    if_addr = 32'h304; bus_rdy = 1'b0;
    step();
    chk("t3_streak_clr", bus_addr, mem_addr);
    bus_rdy = 1'b1; step();
    mem_cmd = NONE; bus_rdy = 1'b0; step();
    bus_rdy = 1'b1; step();
    if_req = 1'b0; bus_rdy = 1'b0; step();

    // 4: BUS_NA is no request.
    mem_cmd = NA; if_req = 1'b1; if_addr = 32'h400;
    #1 chk("t4_memstall", 32'(mem_stall), 32'h0);
    step();
    chk("t4_cmd",  32'(bus_cmd), 32'(LOAD));
    chk("t4_addr", bus_addr, 32'h400);
    bus_rdy = 1'b1; step();
    if_req = 1'b0; mem_cmd = NONE; bus_rdy = 1'b0; step();

    // 5: reset in the middle of a MEM access.
    mem_cmd = LOAD; mem_addr = 32'h500;
    step();
    chk("t5_cmd", 32'(bus_cmd), 32'(LOAD));
    step();
    bus_rdy = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_cmd",  32'(bus_cmd), 32'(NONE));
    chk("t5_rst_addr", bus_addr, 32'h0);
    chk("t5_rst_din",  bus_din,  32'h0);
    chk("t5_rst_memd", 32'(mem_done), 32'h0);
    model_reset();
    @(negedge clk);
    chk("t5_rst_memd2", 32'(mem_done), 32'h0);
    rst = 1'b1; bus_rdy = 1'b0;
    step();
    chk("t5_reissue_cmd",  32'(bus_cmd), 32'(LOAD));
    chk("t5_reissue_addr", bus_addr, 32'h500);
    bus_rdy = 1'b1; step();
    mem_cmd = NONE; bus_rdy = 1'b0; step();

    // 6: spurious bus_rdy while idle.
    bus_rdy = 1'b1;
    #1;
    chk("t6_ifd",  32'(if_done),  32'h0);
    chk("t6_memd", 32'(mem_done), 32'h0);
    step();
    chk("t6_cmd", 32'(bus_cmd), 32'(NONE));
    step();
    bus_rdy = 1'b0;

    // Randomized traffic obeying the hold-until-done protocol.
    for (int n = 0; n < 400; n++) begin
      if (!if_req || last_ifd) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!((mem_cmd == LOAD) || (mem_cmd == STORE)) || last_memd) begin
        mem_cmd  = 2'($urandom_range(0, 3));
        mem_addr = $urandom;
        mem_din  = $urandom;
      end
      bus_rdy  = ($urandom_range(0, 2) == 0);
      bus_dout = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
